// File: rtl/axis_tpg_pkg.sv
// Shared types and constants for the AXI4-Stream test pattern generator:
// pattern mode encoding, Galois LFSR tap masks and the checkerboard seed.
package axis_tpg_pkg;

  typedef enum logic [1:0] {
    TPG_COUNTER = 2'd0,
    TPG_PRBS    = 2'd1,
    TPG_WALK    = 2'd2,
    TPG_CHECKER = 2'd3
  } tpg_mode_e;

  // Right-shifting Galois masks for maximal-length polynomials.
  localparam logic [63:0] LFSR_TAPS_8  = 64'h0000_0000_0000_00B8;
  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  // Widths without a table entry get a non-zero (not maximal) fallback mask.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      64:      return LFSR_TAPS_64;
      default: return (64'd1 << (width - 1)) | 64'd1;
    endcase
  endfunction

  function automatic logic [63:0] checker_seed();
    return {32{2'b01}};
  endfunction

endpackage

// File: rtl/axis_pattern_generator_mc_if.sv
// AXI4-Stream beat bundle shared by the pattern source (master) and its sink (slave).
interface axis_pattern_generator_mc_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_tpg_pattern.sv
// Pattern value register: reloads a mode seed or steps to the next beat value.
// The PRBS branch exists only when AXIS_TPG_PRBS_EN is defined; otherwise mode 1 steps as a counter.
module axis_tpg_pattern
  import axis_tpg_pkg::*;
#(
  parameter int TDATA_WIDTH   = 32,
  parameter int COUNTER_START = 0,
  parameter int COUNTER_END   = 255,
  parameter int COUNTER_INCR  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  tpg_mode_e              mode,
  input  logic                   reload,
  input  logic                   advance,
  output logic [TDATA_WIDTH-1:0] value
);

  localparam logic signed [TDATA_WIDTH-1:0] START_V  = TDATA_WIDTH'(COUNTER_START);
  localparam logic signed [TDATA_WIDTH-1:0] WRAP_THR = TDATA_WIDTH'(COUNTER_END - COUNTER_INCR + 1);
  localparam logic signed [TDATA_WIDTH-1:0] WRAP_ADJ =
    TDATA_WIDTH'(COUNTER_INCR - (COUNTER_END - COUNTER_START) - 1);
  localparam logic signed [TDATA_WIDTH-1:0] INCR_V   = TDATA_WIDTH'(COUNTER_INCR);
  localparam logic [63:0]                   CHK_64   = checker_seed();
  localparam logic [TDATA_WIDTH-1:0]        CHK_SEED = CHK_64[TDATA_WIDTH-1:0];
`ifdef AXIS_TPG_PRBS_EN
  localparam logic [63:0]                   TAPS_64  = lfsr_taps(TDATA_WIDTH);
  localparam logic [TDATA_WIDTH-1:0]        TAPS     = TAPS_64[TDATA_WIDTH-1:0];
`endif

  logic [TDATA_WIDTH-1:0] seed_v;
  logic [TDATA_WIDTH-1:0] next_v;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    seed_v = START_V;
    next_v = ($signed(value) >= WRAP_THR) ? value + WRAP_ADJ : value + INCR_V;
    case (mode)
`ifdef AXIS_TPG_PRBS_EN
      TPG_PRBS: begin
        seed_v = '1;
        next_v = value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
      end
`endif
      TPG_WALK: begin
        seed_v = TDATA_WIDTH'(1);
        next_v = {value[TDATA_WIDTH-2:0], value[TDATA_WIDTH-1]};
      end
      TPG_CHECKER: begin
        seed_v = CHK_SEED;
        next_v = ~value;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)          value <= START_V;
    else if (reload)  value <= seed_v;
    else if (advance) value <= next_v;
  end

endmodule

// File: rtl/axis_pattern_generator_mc.sv
// Rate-limited multi-mode AXI4-Stream pattern source with packet framing and backlog/overflow tracking.
// Define AXIS_TPG_PRBS_EN to build the PRBS mode; without it mode 1 produces the counter sequence.
module axis_pattern_generator_mc
  import axis_tpg_pkg::*;
#(
  parameter int TDATA_WIDTH   = 32,
  parameter int COUNTER_START = 0,
  parameter int COUNTER_END   = 255,
  parameter int COUNTER_INCR  = 1,
  parameter int DIVIDER       = 8,
  parameter int PKT_LEN       = 16,
  parameter int BACKLOG_DEPTH = 16
) (
  input  logic                                   m_axis_aclk,
  input  logic                                   m_axis_areset,
  input  logic                                   enable,
  input  logic [1:0]                             mode,
  axis_pattern_generator_mc_if.master            m_axis,
  output logic [$clog2(BACKLOG_DEPTH+1)-1:0]     backlog,
  output logic                                   overflow
);

  localparam int BL_W  = $clog2(BACKLOG_DEPTH + 1);
  localparam int DIV_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);
  localparam logic [BL_W-1:0]  BL_FULL  = BL_W'(BACKLOG_DEPTH);

  logic [DIV_W-1:0]       div_cnt;
  logic [IDX_W-1:0]       idx;
  tpg_mode_e              active_mode;
  tpg_mode_e              req_mode;
  tpg_mode_e              pat_mode;
  logic                   started;
  logic                   valid;
  logic                   tick;
  logic                   hs;
  logic                   drop;
  logic                   accept;
  logic                   latch;
  logic                   reload;
  logic [TDATA_WIDTH-1:0] pat_value;

  assign valid  = (backlog != '0);
  assign tick   = (div_cnt == '0) && enable;
  assign hs     = valid && m_axis.tready;
  assign drop   = tick && (backlog == BL_FULL) && !hs;
  assign accept = tick && !drop;

  // Mode is sampled on the first cycle out of reset and on each packet boundary.
  assign latch = !started || (hs && idx == IDX_LAST);

  always_comb begin
    req_mode = tpg_mode_e'(mode);
`ifndef AXIS_TPG_PRBS_EN
    if (req_mode == TPG_PRBS) req_mode = TPG_COUNTER;
`endif
  end

  // Re-seeding only on a real mode change keeps a steady-mode sequence continuous across packets.
  assign reload   = latch && (req_mode != active_mode);
  assign pat_mode = reload ? req_mode : active_mode;

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      div_cnt     <= DIV_LAST;
      backlog     <= '0;
      overflow    <= 1'b0;
      idx         <= '0;
      active_mode <= TPG_COUNTER;
      started     <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == '0) ? DIV_LAST : div_cnt - 1'b1;
      started <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (accept && !hs)      backlog <= backlog + 1'b1;
      else if (!accept && hs) backlog <= backlog - 1'b1;
      if (hs) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (latch) active_mode <= req_mode;
    end
  end

  axis_tpg_pattern #(
    .TDATA_WIDTH   (TDATA_WIDTH),
    .COUNTER_START (COUNTER_START),
    .COUNTER_END   (COUNTER_END),
    .COUNTER_INCR  (COUNTER_INCR)
  ) u_pattern (
    .clk     (m_axis_aclk),
    .rst     (m_axis_areset),
    .mode    (pat_mode),
    .reload  (reload),
    .advance (hs),
    .value   (pat_value)
  );

  assign m_axis.tdata  = pat_value;
  assign m_axis.tvalid = valid;
  assign m_axis.tlast  = valid && (idx == IDX_LAST);

endmodule

// File: doc/axis_pattern_generator_mc.md
# axis_pattern_generator_mc

Multi-mode AXI4-Stream test pattern source for link bring-up and DMA/FIFO soak testing. Emits a rate-limited stream (counter, PRBS, walking-one or checkerboard) with packet framing on TLAST, absorbs downstream back-pressure in a bounded backlog counter, and flags lost beats. Sits at the head of a stream chain in place of a data source, driving any AXIS slave.

## Interface
- TDATA_WIDTH, 32: output data width (8..64).
- COUNTER_START, 0: counter mode first/wrap value.
- COUNTER_END, 255: counter mode last value before wrap.
- COUNTER_INCR, 1: counter mode step (>=1).
- DIVIDER, 8: one generation tick per DIVIDER clocks (>=1).
- PKT_LEN, 16: beats per packet (>=1).
- BACKLOG_DEPTH, 16: max ticks pending handshake (>=1).

- m_axis_aclk  in  1  clock; sole clock domain.
- m_axis_areset  in  1  reset, synchronous, active-high.
- enable  in  1  gates generation ticks.
- mode  in  2  0 counter, 1 PRBS, 2 walking-one, 3 checkerboard.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tdata  out  TDATA_WIDTH  pattern beat.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tlast  out  1  last beat of packet.
- backlog  out  $clog2(BACKLOG_DEPTH+1)  ticks pending.
- overflow  out  1  sticky: a tick was dropped.

## Operation
- Divider: free-running down-counter, reset to DIVIDER-1, reloads on zero; tick = (count==0) && enable. Not cleared by enable.
- Backlog: tick with backlog<BACKLOG_DEPTH → +1; handshake (tvalid&&tready) → -1; both same cycle → unchanged. Tick at full with no handshake → dropped, overflow set until reset, pattern not advanced (output sequence stays gap-free).
- m_axis_tvalid = (backlog!=0). Beat holds tdata/tlast stable while tvalid && !tready.
- Pattern advances only on handshake. Beat index 0..PKT_LEN-1 increments on handshake, wraps after PKT_LEN-1; tlast = tvalid && index==PKT_LEN-1.
- Active mode latched from `mode` at reset release and on the tlast handshake; latch reloads the pattern seed. Mode changes mid-packet take effect at next packet.
- Counter: seed COUNTER_START; next = (v >= COUNTER_END-COUNTER_INCR+1) ? v+COUNTER_INCR-(COUNTER_END-COUNTER_START)-1 : v+COUNTER_INCR, in TDATA_WIDTH signed arithmetic.
- PRBS: Galois LFSR, width TDATA_WIDTH, maximal-length taps from package, seed all-ones, one LFSR step per beat; never zero.
- Walking-one: seed 1, rotate left one bit per beat.
- Checkerboard: seed 0x55..55, invert each beat.

## Timing
- Reset values: tvalid 0, tlast 0, tdata COUNTER_START (mode 0 seed), backlog 0, overflow 0, divider DIVIDER-1, index 0.
- First tick: DIVIDER-1 clocks after reset release (if enable).
- Tick in cycle k → tvalid high in cycle k+1; tdata registered, valid with tvalid.
- Handshake in cycle k → next beat value in cycle k+1; tvalid drops in k+1 if backlog reaches 0.
- Sustained rate: one beat per DIVIDER clocks; DIVIDER=1 with tready high gives one beat per clock.
- Reset mid-packet: all state cleared next edge; partial packet truncated without tlast (documented, not corrected).

## Configuration
- AXIS_TPG_PRBS_EN defined: mode 1 is PRBS as above, LFSR logic built.
- Undefined: LFSR omitted; mode 1 behaves exactly as mode 0 (counter).

## Structure
- Package axis_tpg_pkg: mode enum typedef (TPG_COUNTER, TPG_PRBS, TPG_WALK, TPG_CHECKER), LFSR tap constants per width 8/16/32/64, checkerboard seed function.
- Sub-module axis_tpg_pattern: holds pattern register; inputs mode, reload, advance; outputs current value. Top holds divider, backlog, packet index, flags.

## Test plan
- Mode 0, DIVIDER=1, START=0, END=255, INCR=1, tready=1 → tdata 0,1,…,255,0 one per clock; tlast every 16th beat (indices 15,31,…).
- Mode 0, START=10, END=20, INCR=3 → 10,13,16,19,11,14,17,20,12,…
- tready=0 for 20 ticks, BACKLOG_DEPTH=16 → backlog saturates 16, overflow=1 at 17th tick; release → exactly 16 consecutive beats, no value skipped.
- Tick and handshake coincident with backlog=1 → backlog stays 1, tvalid stays high.
- Mode switched 0→2 at beat 5 → counter continues to beat 15 (tlast), then 0x1,0x2,0x4,…
- AXIS_TPG_PRBS_EN, TDATA_WIDTH=8, mode 1 → first beat 0xFF, period 255, no zero; without macro → counter sequence.
